key_updown_counter: RTL
=======================

Name: key_updown_counter

Overview:
- Parametrised two-key up/down counter for the board's LED/display path; successor to the single-width key-clocked LED counter.
- Fully synchronous to Sys_CLK: raw keys are synchronised and debounced, press edges are detected, and the counter is updated in the clock domain with no derived clocks.
- Adds selectable wrap or saturate arithmetic, min/max flags, per-event pulses, and optional hold-to-repeat.

Parameters:
- CNT_W, 4, counter width in bits (>=2).
- DEB_CYCLES, 20000, cycles a synchronised key level must stay stable before it is accepted (>=2).
- SATURATE, 0, 0 = wrap-around, 1 = clamp at 0 and 2^CNT_W-1.
- RESET_VAL, 0, counter value loaded on reset (must fit in CNT_W).
- REPEAT_DELAY, 8000000, hold cycles before the first auto-repeat step (used only with the optional feature).
- REPEAT_RATE, 2000000, cycles between subsequent repeat steps (used only with the optional feature).

Ports:
- Sys_CLK  in  1  system clock.
- Sys_RST  in  1  asynchronous, active-low reset.
- Key_In  in  2  raw keys, active-low: bit1 = up, bit0 = down.
- Cnt_Out  out  CNT_W  counter value.
- Up_Pulse  out  1  one-cycle pulse on each increment request (step or repeat).
- Down_Pulse  out  1  one-cycle pulse on each decrement request.
- At_Max  out  1  Cnt_Out == all ones.
- At_Min  out  1  Cnt_Out == 0.

Behaviour:
- Reset (Sys_RST low, asynchronous): Cnt_Out = RESET_VAL; pulses = 0; At_Max/At_Min derived from RESET_VAL; sync flops = 1 (released); debounce counters = 0; debounced levels = released; FSM = IDLE.
- Reset deassertion mid-press: a key held through reset is seen as a new press only after DEB_CYCLES of stable low.
- Synchronisation: 2-flop synchroniser per key, then inverted so that 1 = pressed.
- Debounce, per key:
  - Counter clears whenever the synchronised level equals the debounced level or changes.
  - When the counter reaches DEB_CYCLES-1 with the level unchanged, the debounced level takes the new value.
- Press edge: debounced 0->1, registered one-cycle strobe.
- Latency: raw key edge to Cnt_Out change is exactly 2 + DEB_CYCLES + 2 cycles (sync, debounce, edge register, count register). Up_Pulse/Down_Pulse assert in the same cycle Cnt_Out changes.
- Simultaneous events:
  - Both debounced levels pressed in the same cycle: no count change, no pulses.
  - A press edge on one key while the other is already held is ignored.
- Arithmetic, wrap mode: modulo 2^CNT_W (all-ones + 1 -> 0; 0 - 1 -> all ones).
- Arithmetic, saturate mode:
  - Increment at all-ones and decrement at 0 leave the value unchanged.
  - The pulse still asserts (it reports the request, not the change).
- At_Max/At_Min are combinational from Cnt_Out.
- Release: no action on release edges.

Optional Feature:
- Macro KEY_AUTOREPEAT_EN.
- Defined: repeat FSM with states IDLE -> HOLD -> REPEAT.
  - IDLE: a single-key press edge issues one step and moves to HOLD with the hold counter = 0.
  - HOLD: after REPEAT_DELAY cycles still held, issue one step and move to REPEAT.
  - REPEAT: issue a step every REPEAT_RATE cycles.
  - Release, or the second key pressed, in HOLD or REPEAT returns to IDLE with no step. Saturation does not stop the FSM.
- Undefined: no FSM, no repeat counters; REPEAT_DELAY and REPEAT_RATE are ignored; one step per press only.

Decomposition:
- Package key_pkg:
  - KEY_UP_IDX = 1, KEY_DN_IDX = 0.
  - Repeat FSM state enum (IDLE/HOLD/REPEAT, 2-bit).
  - Function clog2 for debounce/repeat counter widths.
- Sub-module key_debounce (parameter DEB_CYCLES; ports Sys_CLK, Sys_RST, raw key in, debounced level out, press strobe out), instantiated once per key.

Test Plan (use DEB_CYCLES=4, CNT_W=4, REPEAT_DELAY=8, REPEAT_RATE=3 unless noted):
- Reset, then one clean up-press held 20 cycles -> Cnt_Out 0->1 exactly 8 cycles after the raw edge; one Up_Pulse; At_Min falls.
- Up-key bounce of 3-cycle low / 1-cycle high pulses for 12 cycles, then stable low -> exactly one increment, timed from the last stable edge.
- Wrap mode: load 15 via 15 presses, up-press -> 0 with At_Min=1; down-press at 0 -> 15 with At_Max=1. SATURATE=1 run: up at 15 stays 15 with Up_Pulse=1; down at 0 stays 0.
- Both keys pressed in the same cycle for 10 cycles -> no change, no pulses. Down held, then up pressed -> up ignored.
- Sys_RST asserted while the counter is 7 and the up key is held -> Cnt_Out = RESET_VAL immediately (async). After release with the key still held, an increment occurs 4 stable cycles after reset deasserts plus the pipeline delay.
- KEY_AUTOREPEAT_EN defined, up held 30 cycles after debounce -> steps at t0, t0+8, t0+11, t0+14, ...; stops immediately on release. Macro undefined, same stimulus -> a single step.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: shared key indices, repeat-FSM state type and width helper for
// the two-key up/down counter.
package key_pkg;

  // Bit positions of the keys on the raw key bus.
  localparam int unsigned KEY_UP_IDX = 1;
  localparam int unsigned KEY_DN_IDX = 0;

  // Auto-repeat state machine states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to count 0 .. n-1 (never less than one bit).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    for (w = 1; (32'd1 << w) < n; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser, stability debouncer and registered
// press-edge strobe for one raw active-low key. key_level = 1 while the key
// is accepted as pressed; key_press pulses for one cycle on each new press.
module key_debounce import key_pkg::*; #(
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic Sys_CLK,
  input  logic Sys_RST,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int unsigned      DEB_W    = clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             key_sync;
  logic [DEB_W-1:0] deb_cnt;
  logic             level_d;

  // Synchronised level in pressed-high sense.
  assign key_sync = ~sync_q2;

  // Synchronise the raw key; both flops rest at the released (high) level.
  // NOTE: Sys_RST sits in the sensitivity list so reset acts without a clock edge.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, giving a true two-stage shift.
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed from the current one for DEB_CYCLES samples in a row.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      deb_cnt   <= '0;
      key_level <= 1'b0;
    end else if (key_sync == key_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      key_level <= key_sync;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // Registered one-cycle strobe on the accepted released->pressed transition.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      level_d   <= 1'b0;
      key_press <= 1'b0;
    end else begin
      level_d   <= key_level;
      key_press <= key_level & ~level_d;
    end
  end

endmodule

// File: rtl/key_updown_counter.sv
// key_updown_counter: two-key (up/down) counter for the LED/display path.
// Keys are synchronised and debounced in the Sys_CLK domain; each accepted
// single-key press steps the counter by one, wrapping or saturating.
// Optional build macro KEY_AUTOREPEAT_EN adds hold-to-repeat stepping.
module key_updown_counter import key_pkg::*; #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned DEB_CYCLES   = 20000,
  parameter bit          SATURATE     = 1'b0,
  parameter int unsigned RESET_VAL    = 0,
  parameter int unsigned REPEAT_DELAY = 8000000,
  parameter int unsigned REPEAT_RATE  = 2000000
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  input  logic [1:0]       Key_In,
  output logic [CNT_W-1:0] Cnt_Out,
  output logic             Up_Pulse,
  output logic             Down_Pulse,
  output logic             At_Max,
  output logic             At_Min
);

  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RESET_VAL);
  localparam logic [CNT_W-1:0] CNT_TOP = '1;

  logic [1:0] key_level;
  logic [1:0] key_press;
  logic       up_lvl;
  logic       dn_lvl;
  logic       up_ok;
  logic       dn_ok;
  logic       up_req;
  logic       dn_req;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
      .Sys_CLK   (Sys_CLK),
      .Sys_RST   (Sys_RST),
      .key_raw   (Key_In[k]),
      .key_level (key_level[k]),
      .key_press (key_press[k])
    );
  end

  assign up_lvl = key_level[KEY_UP_IDX];
  assign dn_lvl = key_level[KEY_DN_IDX];

  // A press counts only while the other key is not held; this also drops
  // presses of both keys accepted in the same cycle.
  assign up_ok = key_press[KEY_UP_IDX] & ~dn_lvl;
  assign dn_ok = key_press[KEY_DN_IDX] & ~up_lvl;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W    = clog2(RPT_SPAN);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  rpt_state_e       rpt_state;
  logic             rpt_up;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_held;
  logic             rpt_due;

  // The repeating key is still the only key held.
  assign rpt_held = rpt_up ? (up_lvl & ~dn_lvl) : (dn_lvl & ~up_lvl);
  assign rpt_due  = (rpt_state == ST_HOLD) ? (rpt_cnt == DELAY_LAST) : (rpt_cnt == RATE_LAST);

  // Step requests: press edges in IDLE, timer expiries while held otherwise.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    up_req = 1'b0;
    dn_req = 1'b0;
    if (rpt_state == ST_IDLE) begin
      up_req = up_ok;
      dn_req = dn_ok;
    end else if (rpt_held && rpt_due) begin
      up_req = rpt_up;
      dn_req = ~rpt_up;
    end
  end

  // Repeat FSM: IDLE -> HOLD on a press, HOLD -> REPEAT after the delay,
  // back to IDLE on release or when the other key joins in.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      rpt_state <= ST_IDLE;
      rpt_up    <= 1'b0;
      rpt_cnt   <= '0;
    end else begin
      case (rpt_state)
        ST_IDLE: begin
          if (up_ok || dn_ok) begin
            rpt_state <= ST_HOLD;
            rpt_up    <= up_ok;
            rpt_cnt   <= '0;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!rpt_held) begin
            rpt_state <= ST_IDLE;
          end else if (rpt_due) begin
            rpt_state <= ST_REPEAT;
            rpt_cnt   <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
          end
        end
        default: rpt_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign up_req = up_ok;
  assign dn_req = dn_ok;

  // Repeat timing has no hardware in this build; the parameters stay on the
  // interface so instantiations are identical in both builds.
  if (REPEAT_DELAY == 0 && REPEAT_RATE == 0) begin : g_repeat_unused
  end
`endif

  // Count register and request pulses; saturation suppresses the change but not the pulse.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      Cnt_Out    <= CNT_RST;
      Up_Pulse   <= 1'b0;
      Down_Pulse <= 1'b0;
    end else begin
      Up_Pulse   <= up_req;
      Down_Pulse <= dn_req;
      if (up_req) begin
        if (!(SATURATE && (Cnt_Out == CNT_TOP))) Cnt_Out <= Cnt_Out + CNT_W'(1);
      end else if (dn_req) begin
        if (!(SATURATE && (Cnt_Out == '0))) Cnt_Out <= Cnt_Out - CNT_W'(1);
      end
    end
  end

  assign At_Max = (Cnt_Out == CNT_TOP);
  assign At_Min = (Cnt_Out == '0);

endmodule
